bit_serial_sub_ctrl: RTL and testbench

- Sequences one single-bit full-subtractor cell (the team's `full_sub`: ports a, b, borrowIn, diff, borrowOut) over WIDTH cycles to perform a WIDTH-bit subtraction with borrow.
- Operands are latched on a start handshake and processed LSB first, one bit per clock.
- The result and final borrow are presented with a one-cycle done pulse.
- Used where area matters more than latency; trades one cell plus a small FSM for a ripple-borrow subtractor.

---
 rtl/bit_serial_sub_ctrl.sv | 139 +++++++++++++
 tb/tb_bit_serial_sub_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_sub_ctrl.sv
// Bit-serial subtractor: one full_sub cell is reused over WIDTH clocks to
// subtract two WIDTH-bit operands, LSB first, with a ripple borrow held in
// a flop between bits. The result is published together with a one-cycle
// done pulse.

// Single-bit full subtractor: diff = a - b - borrowIn, borrowOut on underflow.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic borrowIn,
  output logic diff,
  output logic borrowOut
);

  assign diff      = a ^ b ^ borrowIn;
  assign borrowOut = (~a & b) | (~(a ^ b) & borrowIn);

endmodule

module bit_serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrowIn,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrowOut
);

  localparam int              CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             cell_diff;
  logic             cell_bout;
  logic [WIDTH-1:0] res_ins;

  // The shared cell always looks at the current LSBs and the running borrow.
  full_sub u_cell (
    .a         (a_sh_q[0]),
    .b         (b_sh_q[0]),
    .borrowIn  (brw_q),
    .diff      (cell_diff),
    .borrowOut (cell_bout)
  );

  // State and datapath registers; reset clears everything, including the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      diff_q   <= '0;
      brw_q    <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      diff_q   <= diff_d;
      brw_q    <= brw_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and datapath update: accept in IDLE/DONE, one bit per RUN cycle.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    diff_d   = diff_q;
    brw_d    = brw_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;
    // Cell result positioned at the MSB; works for WIDTH=1 without a zero-width slice.
    res_ins  = '0;
    res_ins[WIDTH-1] = cell_diff;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          brw_d   = borrowIn;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_sh_d = (res_sh_q >> 1) | res_ins;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        brw_d    = cell_bout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          // Last bit: publish the completed result and the final borrow.
          diff_d  = (res_sh_q >> 1) | res_ins;
          bout_d  = cell_bout;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready     = (state_q == IDLE) || (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign diff      = diff_q;
  assign borrowOut = bout_q;

endmodule

// File: tb/tb_bit_serial_sub_ctrl.sv
// Bench for bit_serial_sub_ctrl: an 8-bit instance for the directed and
// multi-cycle scenarios, and a 4-bit instance swept over every operand
// combination in random order against an arithmetic reference.
module tb_bit_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst;

  logic       start8, bin8, ready8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic       start4, bin4, ready4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  bit_serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .borrowIn(bin8),
    .ready(ready8), .busy(busy8), .done(done8), .diff(diff8), .borrowOut(bout8)
  );

  bit_serial_sub_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .borrowIn(bin4),
    .ready(ready4), .busy(busy4), .done(done4), .diff(diff4), .borrowOut(bout4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer subtraction, borrow is the sign of the true result.
  function automatic logic [4:0] ref_sub4(input int a, input int b, input int bin);
    int r;
    r = a - b - bin;
    ref_sub4 = {(r < 0) ? 1'b1 : 1'b0, 4'(r & 15)};
  endfunction

  // Called just after a negedge with ready8=1; leaves off one cycle after done.
  task automatic run8(input vec_t v, input string nm);
    logic [7:0] prev;
    int k, nb;
    bit held;
    prev = diff8;
    a8 = v.a; b8 = v.b; bin8 = v.bin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = ~v.a; b8 = 8'($urandom); bin8 = ~v.bin;
    k = 1; nb = 0; held = 1'b1;
    while (!done8 && k < 20) begin
      if (busy8) nb++;
      if (diff8 !== prev) held = 1'b0;
      @(negedge clk);
      k++;
    end
    chk({nm, " done_latency"}, 64'(k), 64'd9);
    chk({nm, " busy_cycles"}, 64'(nb), 64'd8);
    chk({nm, " diff_held_in_run"}, 64'(held), 64'd1);
    chk({nm, " diff"}, 64'(diff8), 64'(v.d));
    chk({nm, " borrowOut"}, 64'(bout8), 64'(v.bo));
    chk({nm, " ready_at_done"}, 64'(ready8), 64'd1);
    @(negedge clk);
    chk({nm, " done_one_cycle"}, 64'(done8), 64'd0);
    chk({nm, " diff_kept"}, 64'(diff8), 64'(v.d));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, ndone, last_done, g;
    int order[512];
    logic [4:0] exp4;

    vecs[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 8'h80, 1'b1, 8'h7E, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
    vecs[7] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1};

    // Reset for two cycles with start asserted.
    rst = 1'b1; start8 = 1'b1; a8 = 8'h5A; b8 = 8'h23; bin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst ready", 64'(ready8), 64'd1);
    chk("rst busy", 64'(busy8), 64'd0);
    chk("rst done", 64'(done8), 64'd0);
    chk("rst diff", 64'(diff8), 64'd0);
    chk("rst borrowOut", 64'(bout8), 64'd0);
    rst = 1'b0; start8 = 1'b0;
    @(negedge clk);
    chk("rst start_dropped", 64'(busy8), 64'd0);

    // Directed vectors.
    for (int i = 0; i < 8; i++) run8(vecs[i], $sformatf("vec%0d", i));

    // start held high: back-to-back operations, junk operands during RUN.
    a8 = 8'hFF; b8 = 8'h80; bin8 = 1'b1; start8 = 1'b1;
    ndone = 0; last_done = 0;
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      if (done8) begin
        ndone++;
        chk("b2b spacing", 64'(c - last_done), 64'd9);
        chk("b2b diff", 64'(diff8), 64'h7E);
        chk("b2b borrowOut", 64'(bout8), 64'd0);
        last_done = c;
      end
      if (c == 27) start8 = 1'b0;
      else if (done8) begin a8 = 8'hFF; b8 = 8'h80; bin8 = 1'b1; end
      else begin a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom); end
    end
    chk("b2b done_count", 64'(ndone), 64'd3);
    @(negedge clk);
    chk("b2b idle_after", 64'(busy8), 64'd0);

    // Reset on the 4th RUN cycle aborts without a done pulse.
    a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort ready", 64'(ready8), 64'd1);
    chk("abort busy", 64'(busy8), 64'd0);
    chk("abort diff", 64'(diff8), 64'd0);
    g = 0;
    for (int c = 0; c < 12; c++) begin
      if (done8) g++;
      @(negedge clk);
    end
    chk("abort no_done", 64'(g), 64'd0);
    run8('{8'h33, 8'h11, 1'b0, 8'h22, 1'b0}, "after_abort");

    // Reset during the DONE cycle clears the result.
    a8 = 8'h00; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    k = 1;
    while (!done8 && k < 20) begin @(negedge clk); k++; end
    chk("rstdone pre_diff", 64'(diff8), 64'hFF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstdone diff", 64'(diff8), 64'd0);
    chk("rstdone borrowOut", 64'(bout8), 64'd0);
    chk("rstdone done", 64'(done8), 64'd0);

    // WIDTH=4: every (a, b, borrowIn) combination, shuffled, random gaps.
    for (int i = 0; i < 512; i++) order[i] = i;
    for (int i = 511; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    @(negedge clk);
    for (int i = 0; i < 512; i++) begin
      int idx;
      idx = order[i];
      a4 = 4'(idx >> 5); b4 = 4'(idx >> 1); bin4 = 1'(idx);
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'($urandom_range(1, 0)) & busy4;
      a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
      k = 1;
      while (!done4 && k < 12) begin @(negedge clk); k++; start4 = 1'b0; end
      start4 = 1'b0;
      exp4 = ref_sub4(idx >> 5, (idx >> 1) & 15, idx & 1);
      chk($sformatf("w4 latency %0h-%0h-%0h", idx >> 5, (idx >> 1) & 15, idx & 1), 64'(k), 64'd5);
      chk($sformatf("w4 diff %0h-%0h-%0h", idx >> 5, (idx >> 1) & 15, idx & 1), 64'(diff4), 64'(exp4[3:0]));
      chk($sformatf("w4 borrow %0h-%0h-%0h", idx >> 5, (idx >> 1) & 15, idx & 1), 64'(bout4), 64'(exp4[4]));
      g = int'($urandom_range(2, 0));
      for (int w = 0; w < g; w++) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
